// File: rtl/ring_counter_pkg.sv
// Shared constants and the HOME-pattern helper for the ring/Johnson counter.
package ring_counter_pkg;

   localparam logic MODE_RING    = 1'b0;
   localparam logic MODE_JOHNSON = 1'b1;
   localparam logic DIR_RIGHT    = 1'b0;
   localparam logic DIR_LEFT     = 1'b1;

   // Widest counter the helper can describe; callers truncate to their WIDTH.
   localparam int unsigned MAX_WIDTH = 64;

   // HOME: ring = MSB one-hot, Johnson = all zeros.
   function automatic logic [MAX_WIDTH-1:0] home_pattern(input logic mode,
                                                         input int unsigned width);
      logic [MAX_WIDTH-1:0] v;
      v = '0;
      if (mode == MODE_RING) begin
         v = MAX_WIDTH'(1) << (width - 1);
      end
      return v;
   endfunction

endpackage

// File: rtl/ring_johnson_counter_if.sv
// Control/status bundle between a sequencer client and ring_johnson_counter.
interface ring_johnson_counter_if #(
   parameter int unsigned WIDTH = 4
);
   logic             en;
   logic             mode;
   logic             dir;
   logic             ld;
   logic [WIDTH-1:0] ld_val;
   logic [WIDTH-1:0] count;
   logic             tc;
   logic             err;

   modport master (
      output en, mode, dir, ld, ld_val,
      input  count, tc, err
   );

   modport slave (
      input  en, mode, dir, ld, ld_val,
      output count, tc, err
   );
endinterface

// File: rtl/ring_johnson_counter_next.sv
// Combinational successor and legality check for the ring/Johnson state.
module ring_next
   import ring_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic [WIDTH-1:0] count,
   input  logic             mode,
   input  logic             dir,
   output logic [WIDTH-1:0] nxt,
   output logic             legal
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   logic [CW-1:0] w_ones;
   logic [CW-1:0] w_edges;
   logic          w_fb_right;
   logic          w_fb_left;

   // Popcount for ring legality; linear bit transitions for Johnson legality
   // (a Johnson state is a single 1-run anchored at MSB or LSB, so <=1 edge).
   always_comb begin
      w_ones  = '0;
      w_edges = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         w_ones = w_ones + CW'(count[i]);
      end
      for (int i = 0; i < int'(WIDTH) - 1; i++) begin
         w_edges = w_edges + CW'(count[i] ^ count[i+1]);
      end
      legal = (mode == MODE_RING) ? (w_ones == CW'(1)) : (w_edges <= CW'(1));
   end

   // Rotate for ring, twisted rotate for Johnson.
   always_comb begin
      w_fb_right = (mode == MODE_JOHNSON) ? ~count[0]       : count[0];
      w_fb_left  = (mode == MODE_JOHNSON) ? ~count[WIDTH-1] : count[WIDTH-1];
      if (dir == DIR_RIGHT) begin
         nxt = {w_fb_right, count[WIDTH-1:1]};
      end else begin
         nxt = {count[WIDTH-2:0], w_fb_left};
      end
   end

endmodule

// File: rtl/ring_johnson_counter.sv
// Parametrised ring / Johnson sequencer with load, self-correction and wrap pulse.
module ring_johnson_counter
   import ring_counter_pkg::*;
#(
   parameter int unsigned WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   ring_johnson_counter_if.slave bus
);

   logic [WIDTH-1:0] r_count;
   logic             r_mode_q;
   logic             r_tc;
   logic             r_err;

   logic [WIDTH-1:0] w_home;
   logic [WIDTH-1:0] w_nxt;
   logic             w_legal;
   logic [WIDTH-1:0] w_count_d;
   logic             w_mode_d;
   logic             w_tc_d;
   logic             w_err_d;

   // HOME always follows the live mode input: on reset and mode change that is
   // the new mode, otherwise it equals the registered mode.
   assign w_home = WIDTH'(home_pattern(bus.mode, WIDTH));

   ring_next #(.WIDTH(WIDTH)) u_next (
      .count (r_count),
      .mode  (r_mode_q),
      .dir   (bus.dir),
      .nxt   (w_nxt),
      .legal (w_legal)
   );

   // Priority mux: mode change > load > enabled step > hold.
   always_comb begin
      w_count_d = r_count;
      w_mode_d  = r_mode_q;
      w_tc_d    = 1'b0;
      w_err_d   = 1'b0;
      if (bus.mode != r_mode_q) begin
         w_count_d = w_home;
         w_mode_d  = bus.mode;
      end else if (bus.ld) begin
         w_count_d = bus.ld_val;
      end else if (bus.en) begin
         if (w_legal) begin
            w_count_d = w_nxt;
            w_tc_d    = (w_nxt == w_home);
         end else begin
            w_count_d = w_home;
            w_err_d   = 1'b1;
         end
      end
   end

   // State and status registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_count  <= w_home;
         r_mode_q <= bus.mode;
         r_tc     <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_count  <= w_count_d;
         r_mode_q <= w_mode_d;
         r_tc     <= w_tc_d;
         r_err    <= w_err_d;
      end
   end

   assign bus.count = r_count;
   assign bus.tc    = r_tc;
   assign bus.err   = r_err;

endmodule
